// File: rtl/path_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : path_pkg
//  Description : Shared definitions for the maze path store: FSM state
//                encodings and default coordinate width / path depth.
//  Revision    : 1.0 - initial release
// ============================================================================
package path_pkg;

   localparam int c_W_DEFAULT     = 4;
   localparam int c_DEPTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage : path_pkg
`default_nettype wire

// File: rtl/path_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : path_reader_if
//  Description : Push/pop command and replay stream bundle between the
//                solver/consumer side (master) and the path store (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface path_reader_if
   import path_pkg::*;
#(
   parameter int W     = c_W_DEFAULT,
   parameter int DEPTH = c_DEPTH_DEFAULT
);
   localparam int c_CW = $clog2(DEPTH) + 1;

   logic            push;
   logic            pop;
   logic [W-1:0]    xIn;
   logic [W-1:0]    yIn;
   logic            start;
   logic            ready;
   logic [W-1:0]    xOut;
   logic [W-1:0]    yOut;
   logic            valid;
   logic            done;
   logic            fail;
   logic            full;
   logic            empty;
   logic [c_CW-1:0] count;

   modport master (
      output push, pop, xIn, yIn, start, ready,
      input  xOut, yOut, valid, done, fail, full, empty, count
   );

   modport slave (
      input  push, pop, xIn, yIn, start, ready,
      output xOut, yOut, valid, done, fail, full, empty, count
   );

endinterface : path_reader_if
`default_nettype wire

// File: rtl/path_mem.sv
`default_nettype none
// ============================================================================
//  Module      : path_mem
//  Description : DEPTH x DW path storage. Synchronous write, combinational
//                read, independent write and read addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module path_mem #(
   parameter int DW    = 8,
   parameter int DEPTH = 16
) (
   input  wire logic                     clk,
   input  wire logic                     i_we,
   input  wire logic [$clog2(DEPTH)-1:0] i_wr_addr,
   input  wire logic [DW-1:0]            i_wr_data,
   input  wire logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output      logic [DW-1:0]            o_rd_data
);

   logic [DW-1:0] r_mem [DEPTH];

   // Write port: one entry per cycle when enabled.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule : path_mem
`default_nettype wire

// File: rtl/path_reader.sv
`default_nettype none
// ============================================================================
//  Module      : path_reader
//  Description : LIFO store of (x,y) path cells with an oldest-first,
//                non-destructive valid/ready replay and done/fail pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module path_reader
   import path_pkg::*;
#(
   parameter int W     = c_W_DEFAULT,
   parameter int DEPTH = c_DEPTH_DEFAULT
) (
   input  wire logic    clk,
   input  wire logic    rst,
   path_reader_if.slave bus
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_CW = c_AW + 1;

   state_t          r_state;
   logic [c_CW-1:0] r_sp;
   logic [c_AW-1:0] r_rd_ptr;
   logic            r_valid;
   logic            r_done;
   logic            r_fail;
   logic [W-1:0]    r_x;
   logic [W-1:0]    r_y;

   logic            w_idle;
   logic            w_empty;
   logic            w_full;
   logic [c_AW-1:0] w_top_addr;
   logic            w_replace;
   logic            w_push_ok;
   logic            w_pop_ok;
   logic            w_we;
   logic [c_AW-1:0] w_wr_addr;
   logic [c_AW-1:0] w_rd_addr;
   logic [2*W-1:0]  w_rd_data;
   logic            w_accept;
   logic            w_last;
   logic            w_fail_next;

   assign w_idle     = (r_state == S_IDLE);
   assign w_empty    = (r_sp == '0);
   assign w_full     = (r_sp == c_CW'(DEPTH));
   assign w_top_addr = c_AW'(r_sp - c_CW'(1));

   // Stack commands, only meaningful in IDLE without start.
   // push+pop on an empty stack degrades to a plain push.
   assign w_replace = bus.push & bus.pop & ~w_empty;
   assign w_push_ok = bus.push & ((~bus.pop & ~w_full) | (bus.pop & w_empty));
   assign w_pop_ok  = bus.pop & ~bus.push & ~w_empty;
   assign w_we      = w_idle & ~bus.start & (w_replace | w_push_ok);
   assign w_wr_addr = w_replace ? w_top_addr : r_sp[c_AW-1:0];

   // Read address looks one entry ahead so output data can be registered.
   assign w_rd_addr = w_idle ? '0 : (r_rd_ptr + c_AW'(1));
   assign w_accept  = (r_state == S_READ) & r_valid & bus.ready;
   assign w_last    = w_accept & (r_rd_ptr == w_top_addr);

   // Any command the current state cannot honour raises a one-cycle fail.
   assign w_fail_next = w_idle
                      ? (bus.start ? (bus.push | bus.pop)
                                   : ((bus.push & ~bus.pop & w_full) |
                                      (bus.pop & ~bus.push & w_empty)))
                      : (bus.push | bus.pop | bus.start);

   path_mem #(
      .DW    (2 * W),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk       (clk),
      .i_we      (w_we),
      .i_wr_addr (w_wr_addr),
      .i_wr_data ({bus.xIn, bus.yIn}),
      .i_rd_addr (w_rd_addr),
      .o_rd_data (w_rd_data)
   );

   // Control FSM with stack pointer, replay pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_sp     <= '0;
         r_rd_ptr <= '0;
         r_valid  <= 1'b0;
         r_done   <= 1'b0;
         r_fail   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
      end else begin
         r_fail <= w_fail_next;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  if (w_empty) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state  <= S_READ;
                     r_rd_ptr <= '0;
                     r_valid  <= 1'b1;
                     r_x      <= w_rd_data[2*W-1:W];
                     r_y      <= w_rd_data[W-1:0];
                  end
               end else if (w_push_ok) begin
                  r_sp <= r_sp + c_CW'(1);
               end else if (w_pop_ok) begin
                  r_sp <= r_sp - c_CW'(1);
               end
            end
            S_READ: begin
               if (w_last) begin
                  r_state <= S_DONE;
                  r_valid <= 1'b0;
                  r_done  <= 1'b1;
                  r_x     <= '0;
                  r_y     <= '0;
               end else if (w_accept) begin
                  r_rd_ptr <= r_rd_ptr + c_AW'(1);
                  r_x      <= w_rd_data[2*W-1:W];
                  r_y      <= w_rd_data[W-1:0];
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.xOut  = r_x;
   assign bus.yOut  = r_y;
   assign bus.valid = r_valid;
   assign bus.done  = r_done;
   assign bus.fail  = r_fail;
   assign bus.full  = w_full;
   assign bus.empty = w_empty;
   assign bus.count = r_sp;

endmodule : path_reader
`default_nettype wire

// File: tb/tb_path_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_path_reader
//  Description : Scoreboard bench for path_reader: directed push/pop/replay
//                sequences, replay beats checked by a free-running monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_path_reader;

   logic clk;
   logic rst;

   path_reader_if #(.W(4), .DEPTH(16)) bus ();

   path_reader #(.W(4), .DEPTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_tests  = 0;
   int         n_fail   = 0;
   int         vcnt     = 0;
   int         done_cnt = 0;
   logic [7:0] sb [$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Absolute time bound in case the design stalls.
   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Monitor: every valid beat must match the scoreboard head; pop on accept.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.valid) begin
            vcnt++;
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL beat_unexpected: got (%0d,%0d) with empty scoreboard",
                        bus.xOut, bus.yOut);
            end else begin
               if ({bus.xOut, bus.yOut} !== sb[0]) begin
                  n_fail++;
                  $display("FAIL beat_data: got (%0d,%0d) expected (%0d,%0d)",
                           bus.xOut, bus.yOut, sb[0][7:4], sb[0][3:0]);
               end
               if (bus.ready) void'(sb.pop_front());
            end
         end else begin
            n_tests++;
            if (bus.xOut !== 4'd0 || bus.yOut !== 4'd0) begin
               n_fail++;
               $display("FAIL idle_data: got (%0d,%0d) expected (0,0)", bus.xOut, bus.yOut);
            end
         end
         if (bus.done) done_cnt++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int got, input int exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic expect_xy(input int x, input int y);
      logic [3:0] xv;
      logic [3:0] yv;
      xv = x[3:0];
      yv = y[3:0];
      sb.push_back({xv, yv});
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
      bus.start = 1'b0;
      bus.ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      sb.delete();
   endtask

   task automatic do_push(input int x, input int y);
      bus.push = 1'b1;
      bus.xIn  = x[3:0];
      bus.yIn  = y[3:0];
      tick();
      bus.push = 1'b0;
   endtask

   task automatic do_pop();
      bus.pop = 1'b1;
      tick();
      bus.pop = 1'b0;
   endtask

   // Start a replay, optionally poke a push in the first READ cycle, then
   // drive ready from the pattern until done (bounded).
   task automatic run_replay(input logic [7:0] pat, input int plen, input int exp_cycles,
                             input bit poke, input int exp_count);
      int v0;
      int d0;
      bit seen;
      int ec;
      v0   = vcnt;
      d0   = done_cnt;
      seen = 1'b0;
      ec   = exp_cycles;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      if (poke) begin
         bus.push  = 1'b1;
         bus.xIn   = 4'd15;
         bus.yIn   = 4'd15;
         bus.ready = 1'b0;
         tick();
         bus.push = 1'b0;
         check("fail_in_read", bus.fail, 1);
         check("count_in_read", bus.count, exp_count);
         ec++;
      end
      for (int c = 0; c < 200; c++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         bus.ready = pat[c % plen];
         tick();
      end
      bus.ready = 1'b0;
      check("done_seen", seen, 1);
      tick();
      check("done_one_cycle", bus.done, 0);
      check("done_pulses", done_cnt - d0, 1);
      check("valid_cycles", vcnt - v0, ec);
      check("sb_drained", sb.size(), 0);
      check("count_after_replay", bus.count, exp_count);
   endtask

   initial begin
      rst       = 1'b1;
      bus.push  = 1'b0;
      bus.pop   = 1'b0;
      bus.start = 1'b0;
      bus.ready = 1'b0;
      bus.xIn   = 4'd0;
      bus.yIn   = 4'd0;
      do_reset();

      // Reset state
      check("rst_count", bus.count, 0);
      check("rst_empty", bus.empty, 1);
      check("rst_full", bus.full, 0);
      check("rst_valid", bus.valid, 0);
      check("rst_done", bus.done, 0);
      check("rst_fail", bus.fail, 0);

      // 1. Reset in the middle of a replay
      do_push(1, 2); do_push(3, 4); do_push(5, 6);
      expect_xy(1, 2); expect_xy(3, 4); expect_xy(5, 6);
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      bus.ready = 1'b1; tick(); tick();
      bus.ready = 1'b0;
      rst = 1'b1;
      tick();
      check("midrst_valid", bus.valid, 0);
      check("midrst_count", bus.count, 0);
      check("midrst_empty", bus.empty, 1);
      check("midrst_done", bus.done, 0);
      rst = 1'b0;
      sb.delete();
      do_push(8, 8);
      check("midrst_idle_push_count", bus.count, 1);
      check("midrst_idle_push_fail", bus.fail, 0);

      // 2. Three entries, ready held high
      do_reset();
      do_push(1, 2); do_push(3, 4); do_push(5, 6);
      check("push3_count", bus.count, 3);
      expect_xy(1, 2); expect_xy(3, 4); expect_xy(5, 6);
      run_replay(8'b0000_0001, 1, 3, 1'b0, 3);

      // 3. Same entries, ready 1,0,1,0,1 (data held across ready=0)
      expect_xy(1, 2); expect_xy(3, 4); expect_xy(5, 6);
      run_replay(8'b0001_0101, 5, 5, 1'b0, 3);

      // Commands during READ are rejected, stack unchanged
      expect_xy(1, 2); expect_xy(3, 4); expect_xy(5, 6);
      run_replay(8'b0000_0001, 1, 3, 1'b1, 3);

      // 4. Pop on empty, overfill
      do_reset();
      do_pop();
      check("pop_empty_fail", bus.fail, 1);
      check("pop_empty_count", bus.count, 0);
      for (int i = 0; i < 16; i++) begin
         do_push(i, 15 - i);
         check("fill_fail", bus.fail, 0);
      end
      check("fill_count", bus.count, 16);
      check("fill_full", bus.full, 1);
      do_push(7, 7);
      check("overfill_fail", bus.fail, 1);
      check("overfill_count", bus.count, 16);
      for (int i = 0; i < 16; i++) expect_xy(i, 15 - i);
      run_replay(8'b0000_0001, 1, 16, 1'b0, 16);
      do_pop();
      check("pop_full_fail", bus.fail, 0);
      check("pop_full_count", bus.count, 15);
      check("pop_full_notfull", bus.full, 0);
      for (int i = 0; i < 15; i++) expect_xy(i, 15 - i);
      run_replay(8'b0000_0001, 1, 15, 1'b0, 15);

      // 5. Push and pop together replaces the top entry
      do_reset();
      do_push(1, 1); do_push(2, 2);
      bus.pop = 1'b1;
      do_push(9, 9);
      bus.pop = 1'b0;
      check("replace_count", bus.count, 2);
      check("replace_fail", bus.fail, 0);
      expect_xy(1, 1); expect_xy(9, 9);
      run_replay(8'b0000_0001, 1, 2, 1'b0, 2);

      // 6. Start on empty, start with push, repeated replay
      do_reset();
      run_replay(8'b0000_0001, 1, 0, 1'b0, 0);
      bus.start = 1'b1;
      do_push(4, 4);
      bus.start = 1'b0;
      check("start_push_fail", bus.fail, 1);
      check("start_push_done", bus.done, 1);
      check("start_push_count", bus.count, 0);
      tick();
      check("start_push_done_end", bus.done, 0);
      do_push(1, 2); do_push(3, 4);
      expect_xy(1, 2); expect_xy(3, 4);
      run_replay(8'b0000_0001, 1, 2, 1'b0, 2);
      expect_xy(1, 2); expect_xy(3, 4);
      run_replay(8'b0000_0001, 1, 2, 1'b0, 2);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_path_reader
`default_nettype wire
